// File: rtl/tt_um_hf4137_rr_arbiter4_if.sv
// Pin bundle for the four-requester round-robin arbiter. It carries the standard
// TinyTapeout user-project pins apart from the clock and reset.
//   ena     : design enable; low forces the arbiter idle
//   ui_in   : [3:0] request lines, [7:4] unused
//   uio_in  : [0] lock (suppresses the hold timeout), [7:1] unused
//   uo_out  : [3:0] one-hot grant, [5:4] grant index, [6] valid, [7] timeout pulse
//   uio_out : constant zero
//   uio_oe  : constant zero, so every bidirectional pin is an input
// The master modport is the side that drives the pins (the harness or the bench).
// The slave modport is the arbiter itself.
interface tt_um_hf4137_rr_arbiter4_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_hf4137_rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time. It drives the one-hot
// select of a shared resource slot, acting as the scheduling layer above a 2-to-4
// decoder.
//
// Behaviour:
//   - A requester keeps the grant while its request stays high.
//   - A tenure lasts at most HOLD_MAX cycles, unless lock holds it open.
//   - A single dead cycle (GAP) always separates consecutive grants.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset; it clears every output immediately
//   bus   : TinyTapeout pin bundle, slave side (see tt_um_hf4137_rr_arbiter4_if)
//
// Every output is a flop, so there is no combinational path from the inputs to uo_out.
module tt_um_hf4137_rr_arbiter4 #(
  parameter int unsigned HOLD_MAX = 15  // legal 1..15
) (
  input logic                        clk,
  input logic                        rst_n,
  tt_um_hf4137_rr_arbiter4_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGap
  } state_e;

  // Final count of a tenure. A timeout fires on the edge that finds cnt here.
  localparam logic [3:0] CntMax = 4'(HOLD_MAX - 1);

  state_e     state;
  logic [1:0] idx;      // current (or most recent) grant index, also driven out
  logic [1:0] last;     // last granted requester; the priority scan starts after it
  logic [3:0] cnt;      // cycles held so far in this tenure, minus one
  logic [3:0] grant;
  logic       valid;
  logic       timeout;

  logic [3:0] req;
  logic       lock;
  assign req  = bus.ui_in[3:0];
  assign lock = bus.uio_in[0];

  // Round-robin scan: last+1, last+2, last+3, then last itself. Offset 4 wraps to
  // last, so a requester that has just released or timed out wins only when nobody
  // else is asking.
  logic       win_found;
  logic [1:0] win_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!win_found && req[last + 2'(k)]) begin
        win_found = 1'b1;
        win_idx   = last + 2'(k);
      end
    end
  end

  function automatic logic [3:0] decode(input logic [1:0] sel);
    decode = 4'b0001 << sel;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= StIdle;
      idx     <= 2'd0;
      last    <= 2'd3;
      cnt     <= 4'd0;
      grant   <= 4'd0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else if (!bus.ena) begin
      // Disabling mid-tenure counts as a release, so rotation stays fair.
      // This branch takes priority over a coincident timeout, so no pulse is raised.
      if (state == StGrant) begin
        last <= idx;
      end
      state   <= StIdle;
      cnt     <= 4'd0;
      grant   <= 4'd0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        StIdle, StGap: begin
          if (win_found) begin
            state <= StGrant;
            idx   <= win_idx;
            cnt   <= 4'd0;
            grant <= decode(win_idx);
            valid <= 1'b1;
          end else begin
            state <= StIdle;
            grant <= 4'd0;
            valid <= 1'b0;
          end
        end
        StGrant: begin
          if (!req[idx]) begin
            // A release wins over a timeout due on the same edge, so no pulse.
            state <= StGap;
            last  <= idx;
            grant <= 4'd0;
            valid <= 1'b0;
          end else if (!lock && cnt == CntMax) begin
            state   <= StGap;
            last    <= idx;
            grant   <= 4'd0;
            valid   <= 1'b0;
            timeout <= 1'b1;
          end else if (cnt != CntMax) begin
            // Under lock, cnt parks at CntMax. Dropping lock then expires the
            // tenure on the next edge.
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= StIdle;
          grant <= 4'd0;
          valid <= 1'b0;
        end
      endcase
    end
  end

  // The index field keeps the last idx through GAP and IDLE. It is only meaningful
  // while valid is high.
  assign bus.uo_out  = {timeout, valid, idx, grant};
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

  logic unused_pins;
  assign unused_pins = ^{bus.ui_in[7:4], bus.uio_in[7:1]};

endmodule
